// File: rtl/router_pe_eject.sv
`default_nettype none
// ============================================================================
// Module      : router_pe_eject
// Description : Local-PE ejection port of a 2D mesh router. Four link inputs
//               (N/E/S/W) share a round-robin arbiter. Packets addressed to
//               this router are queued in an ejection FIFO toward the PE.
//               Misaddressed packets are dropped and flagged.
//               Optional feature macro: ROUTER_EJECT_MISROUTE_CNT_EN adds a
//               saturating 16-bit count of dropped packets (misroute_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module router_pe_eject #(
    parameter int         WIDTH = 35,
    parameter int         DEPTH = 4,
    parameter logic [1:0] X_ID  = 2'd0,
    parameter logic [1:0] Y_ID  = 2'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       n_valid,
    input  logic                       e_valid,
    input  logic                       s_valid,
    input  logic                       w_valid,
    input  logic [WIDTH-1:0]           n_data,
    input  logic [WIDTH-1:0]           e_data,
    input  logic [WIDTH-1:0]           s_data,
    input  logic [WIDTH-1:0]           w_data,
    output logic                       n_ready,
    output logic                       e_ready,
    output logic                       s_ready,
    output logic                       w_ready,
    output logic                       pe_valid,
    output logic [WIDTH-1:0]           pe_data,
    input  logic                       pe_ready,
    output logic                       err_misroute,
`ifdef ROUTER_EJECT_MISROUTE_CNT_EN
    output logic [15:0]                misroute_cnt,
`endif
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH) + 1;

    // Direction indices: 0=N, 1=E, 2=S, 3=W
    localparam logic [1:0] C_DIR_W = 2'd3;

    logic [3:0]         w_req;
    logic [3:0]         w_grant;
    logic [1:0]         w_grant_idx;
    logic [1:0]         w_scan_idx;
    logic               w_found;
    logic               w_full;
    logic               w_accept;
    logic               w_match;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_sel_data;

    logic [1:0]         r_last;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               r_err;

    assign w_req = {w_valid, s_valid, e_valid, n_valid};

    // Round-robin search starting one past the last granted direction
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = r_last;
        w_scan_idx  = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_scan_idx = r_last + k[1:0];
            if (!w_found && w_req[w_scan_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
        w_grant = w_found ? (4'b0001 << w_grant_idx) : 4'b0000;
    end

    // Select the granted link's packet
    always_comb begin
        case (w_grant_idx)
            2'd0:    w_sel_data = n_data;
            2'd1:    w_sel_data = e_data;
            2'd2:    w_sel_data = s_data;
            default: w_sel_data = w_data;
        endcase
    end

    // A full FIFO blocks every input even when the PE pops this cycle
    assign w_full   = (r_count == C_CNT_W'(DEPTH));
    assign w_accept = w_found & ~w_full & ~rst;
    assign w_match  = (w_sel_data[WIDTH-5:WIDTH-6] == X_ID) &&
                      (w_sel_data[WIDTH-7:WIDTH-8] == Y_ID);
    assign w_push   = w_accept & w_match;
    assign w_pop    = (r_count != '0) & pe_ready;

    assign n_ready  = w_grant[0] & ~w_full & ~rst;
    assign e_ready  = w_grant[1] & ~w_full & ~rst;
    assign s_ready  = w_grant[2] & ~w_full & ~rst;
    assign w_ready  = w_grant[3] & ~w_full & ~rst;

    // Arbiter pointer; reset to West so North is highest priority next
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= C_DIR_W;
        end else if (w_accept) begin
            r_last <= w_grant_idx;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sel_data;
        end
    end

    // FIFO pointers and count; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle pulse the cycle after a misaddressed packet is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_match;
        end
    end

`ifdef ROUTER_EJECT_MISROUTE_CNT_EN
    logic [15:0] r_mis_cnt;

    // Saturating count of dropped packets
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mis_cnt <= '0;
        end else if (w_accept && !w_match && (r_mis_cnt != 16'hFFFF)) begin
            r_mis_cnt <= r_mis_cnt + 16'd1;
        end
    end

    assign misroute_cnt = r_mis_cnt;
`endif

    assign pe_valid     = (r_count != '0);
    assign pe_data      = r_mem[r_rd_ptr];
    assign occupancy    = r_count;
    assign err_misroute = r_err;

endmodule
`default_nettype wire

// File: tb/tb_router_pe_eject.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pe_eject
// Description : Self-checking bench for router_pe_eject (X_ID=1, Y_ID=2,
//               DEPTH=4) with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pe_eject;

    localparam int         WIDTH = 35;
    localparam int         DEPTH = 4;
    localparam logic [1:0] XI    = 2'd1;
    localparam logic [1:0] YI    = 2'd2;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       vld;
    logic [WIDTH-1:0] dat [4];
    logic             pe_rdy;
    logic             n_ready, e_ready, s_ready, w_ready;
    logic             pe_valid;
    logic [WIDTH-1:0] pe_data;
    logic             err_misroute;
    logic [2:0]       occupancy;
    logic [3:0]       rdy;
`ifdef ROUTER_EJECT_MISROUTE_CNT_EN
    logic [15:0]      misroute_cnt;
`endif

    assign rdy = {w_ready, s_ready, e_ready, n_ready};

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [WIDTH-1:0] m_fifo [$];
    int               m_last = 3;
    logic             m_err  = 1'b0;
    int               m_mcnt = 0;

    router_pe_eject #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .X_ID(XI), .Y_ID(YI)
    ) dut (
        .clk(clk), .rst(rst),
        .n_valid(vld[0]), .e_valid(vld[1]), .s_valid(vld[2]), .w_valid(vld[3]),
        .n_data(dat[0]), .e_data(dat[1]), .s_data(dat[2]), .w_data(dat[3]),
        .n_ready(n_ready), .e_ready(e_ready), .s_ready(s_ready), .w_ready(w_ready),
        .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_rdy),
        .err_misroute(err_misroute),
`ifdef ROUTER_EJECT_MISROUTE_CNT_EN
        .misroute_cnt(misroute_cnt),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                            input logic [26:0] pl);
        logic [1:0] sx, sy;
        sx = 2'($urandom);
        sy = 2'($urandom);
        return {sx, sy, dx, dy, pl};
    endfunction

    // First requesting direction after the last one granted, or -1
    function automatic int model_grant();
        for (int k = 1; k <= 4; k++) begin
            int d;
            d = (m_last + k) % 4;
            if (vld[d]) return d;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_rdy();
        int g;
        g = model_grant();
        if (rst || g < 0 || m_fifo.size() >= DEPTH) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    function automatic void model_clock();
        int               g;
        bit               acc;
        logic [WIDTH-1:0] d;
        if (rst) begin
            m_fifo.delete();
            m_last = 3;
            m_err  = 1'b0;
            m_mcnt = 0;
            return;
        end
        g     = model_grant();
        acc   = (g >= 0) && (m_fifo.size() < DEPTH);
        m_err = 1'b0;
        if (m_fifo.size() > 0 && pe_rdy) void'(m_fifo.pop_front());
        if (acc) begin
            m_last = g;
            d = dat[g];
            if (d[WIDTH-5:WIDTH-6] == XI && d[WIDTH-7:WIDTH-8] == YI) begin
                m_fifo.push_back(d);
            end else begin
                m_err = 1'b1;
                if (m_mcnt < 65535) m_mcnt++;
            end
        end
    endfunction

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        vld    = 4'b0000;
        pe_rdy = 1'b1;
        for (int i = 0; i < 20 && m_fifo.size() > 0; i++) tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        vld    = 4'b1111;
        pe_rdy = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = mk(XI, YI, 27'(i));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (rdy !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ready got=%b exp=0000", rdy);
            end
            tick();
        end
        rst = 1'b0;
        vld = 4'b0000;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd0 || pe_valid !== 1'b0 || err_misroute !== 1'b0) begin
            errors++;
            $display("FAIL reset_state occ=%0d pe_valid=%b err=%b exp 0/0/0",
                     occupancy, pe_valid, err_misroute);
        end
        tick();
    endtask

    task automatic test_latency();
        logic [WIDTH-1:0] p;
        p      = mk(XI, YI, 27'h1234);
        dat[1] = p;
        vld    = 4'b0010;
        pe_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 4'b0010) begin
            errors++;
            $display("FAIL latency_ready got=%b exp=0010", rdy);
        end
        tick();
        vld = 4'b0000;
        @(negedge clk);
        checks++;
        if (pe_valid !== 1'b1 || pe_data !== p) begin
            errors++;
            $display("FAIL latency_out pe_valid=%b data=%h exp 1/%h", pe_valid, pe_data, p);
        end
        tick();
        drain();
    endtask

    task automatic test_misroute();
        dat[3] = mk(2'd0, 2'd0, 27'h55);
        vld    = 4'b1000;
        pe_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 4'b1000) begin
            errors++;
            $display("FAIL misroute_ready got=%b exp=1000", rdy);
        end
        tick();
        vld = 4'b0000;
        @(negedge clk);
        checks++;
        if (err_misroute !== 1'b1 || pe_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL misroute_pulse err=%b pe_valid=%b occ=%0d exp 1/0/0",
                     err_misroute, pe_valid, occupancy);
        end
`ifdef ROUTER_EJECT_MISROUTE_CNT_EN
        checks++;
        if (misroute_cnt !== 16'd1) begin
            errors++;
            $display("FAIL misroute_cnt got=%0d exp=1", misroute_cnt);
        end
`endif
        tick();
        @(negedge clk);
        checks++;
        if (err_misroute !== 1'b0) begin
            errors++;
            $display("FAIL misroute_one_cycle err=%b exp=0", err_misroute);
        end
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        vld = 4'b0000;
        tick();
        rst    = 1'b0;
        vld    = 4'b1111;
        pe_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) dat[i] = mk(XI, YI, 27'($urandom));
            @(negedge clk);
            checks++;
            if (rdy !== (4'b0001 << (c % 4))) begin
                errors++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, rdy, 4'b0001 << (c % 4));
            end
            tick();
        end
        drain();
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] p [5];
        int               idx;
        logic             exp_n;
        for (int i = 0; i < 5; i++) p[i] = mk(XI, YI, 27'h100 + 27'(i));
        pe_rdy = 1'b0;
        idx    = 0;
        vld    = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            dat[0] = p[idx];
            @(negedge clk);
            exp_n = (m_fifo.size() < DEPTH);
            checks++;
            if (n_ready !== exp_n) begin
                errors++;
                $display("FAIL full_nready cyc=%0d got=%b exp=%b", c, n_ready, exp_n);
            end
            tick();
            if (exp_n) idx++;
        end
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd4 || idx !== 4) begin
            errors++;
            $display("FAIL full_occ occ=%0d accepted=%0d exp 4/4", occupancy, idx);
        end
        pe_rdy = 1'b1;
        #1;
        checks++;
        if (n_ready !== 1'b0 || pe_data !== p[0]) begin
            errors++;
            $display("FAIL full_pop_block n_ready=%b data=%h exp 0/%h", n_ready, pe_data, p[0]);
        end
        tick();
        vld = 4'b0000;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pe_data !== p[i] || pe_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_drain i=%0d got=%h exp=%h", i, pe_data, p[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        pe_rdy = 1'b0;
        vld    = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            dat[0] = mk(XI, YI, 27'h200 + 27'(c));
            tick();
        end
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_pre occ=%0d exp=2", occupancy);
        end
        rst    = 1'b1;
        vld    = 4'b0100;
        dat[2] = mk(XI, YI, 27'h300);
        #1;
        checks++;
        if (rdy !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_sready got=%b exp=0000", rdy);
        end
        tick();
        rst = 1'b0;
        vld = 4'b1111;
        for (int i = 0; i < 4; i++) dat[i] = mk(XI, YI, 27'h400 + 27'(i));
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd0 || pe_valid !== 1'b0 || rdy !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_post occ=%0d pe_valid=%b rdy=%b exp 0/0/0001",
                     occupancy, pe_valid, rdy);
        end
        tick();
        drain();
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] a, b, c;
        a = mk(XI, YI, 27'h501);
        b = mk(XI, YI, 27'h502);
        c = mk(XI, YI, 27'h503);
        pe_rdy = 1'b0;
        vld    = 4'b0010;
        dat[1] = a;
        tick();
        dat[1] = b;
        tick();
        dat[1] = c;
        pe_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd2 || pe_data !== a || e_ready !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_pre occ=%0d data=%h e_ready=%b exp 2/%h/1",
                     occupancy, pe_data, e_ready, a);
        end
        tick();
        vld = 4'b0000;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd2 || pe_data !== b) begin
            errors++;
            $display("FAIL pushpop_same occ=%0d data=%h exp 2/%h", occupancy, pe_data, b);
        end
        tick();
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd1 || pe_data !== c) begin
            errors++;
            $display("FAIL pushpop_order occ=%0d data=%h exp 1/%h", occupancy, pe_data, c);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 59) == 0);
            vld    = 4'($urandom);
            pe_rdy = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0)
                    dat[i] = mk(2'($urandom), 2'($urandom), 27'($urandom));
                else
                    dat[i] = mk(XI, YI, 27'($urandom));
            end
            @(negedge clk);
            checks++;
            if (rdy !== model_rdy()) begin
                errors++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, rdy, model_rdy());
            end
            checks++;
            if (pe_valid !== (m_fifo.size() > 0)) begin
                errors++;
                $display("FAIL rand_pe_valid cyc=%0d got=%b exp=%b", c, pe_valid, m_fifo.size() > 0);
            end
            if (m_fifo.size() > 0) begin
                checks++;
                if (pe_data !== m_fifo[0]) begin
                    errors++;
                    $display("FAIL rand_pe_data cyc=%0d got=%h exp=%h", c, pe_data, m_fifo[0]);
                end
            end
            checks++;
            if (occupancy !== 3'(m_fifo.size())) begin
                errors++;
                $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_fifo.size());
            end
            checks++;
            if (err_misroute !== m_err) begin
                errors++;
                $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, err_misroute, m_err);
            end
`ifdef ROUTER_EJECT_MISROUTE_CNT_EN
            checks++;
            if (misroute_cnt !== 16'(m_mcnt)) begin
                errors++;
                $display("FAIL rand_mcnt cyc=%0d got=%0d exp=%0d", c, misroute_cnt, m_mcnt);
            end
`endif
            tick();
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        rst    = 1'b1;
        vld    = 4'b0000;
        pe_rdy = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        test_reset();
        test_latency();
        test_misroute();
        test_round_robin();
        test_full();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
